// File: rtl/text_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : text_scan_ctrl
// Purpose  : Turns pixel coordinates into text-RAM reads and font-ROM requests.
//            Cursor overlay and blink are built only with TEXT_SCAN_CURSOR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module text_scan_ctrl #(
  parameter int COLS             = 80,
  parameter int ROWS             = 30,
  parameter int TEXT_RAM_LATENCY = 2,
  parameter int BLINK_FRAMES     = 30
) (
  input  logic        clk_hdmi_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        frame_start_in,
  input  logic        active_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [4:0]  scroll_row_in,
  input  logic [6:0]  cursor_col_in,
  input  logic [4:0]  cursor_row_in,
  output logic [11:0] text_addr_out,
  input  logic [15:0] text_data_in,
  output logic        font_valid_out,
  output logic [2:0]  font_x_out,
  output logic [3:0]  font_y_out,
  output logic [7:0]  font_code_point_out,
  output logic [7:0]  font_attribute_out
);

  localparam logic [0:0]  c_st_idle = 1'b0;
  localparam logic [0:0]  c_st_scan = 1'b1;
  localparam int          c_depth   = TEXT_RAM_LATENCY + 1;
  localparam logic [7:0]  c_cols8   = 8'(COLS);
  localparam logic [11:0] c_cols12  = 12'(COLS);
  localparam logic [4:0]  c_rows5   = 5'(ROWS);
  localparam logic [5:0]  c_rows6   = 6'(ROWS);
  localparam logic [6:0]  c_rows7   = 7'(ROWS);

  logic [0:0]  r_state;
  logic [4:0]  r_scroll_q;
  logic [11:0] r_text_addr;
  logic [8:0]  r_dly [c_depth];

  logic [7:0]  w_col;
  logic [5:0]  w_row;
  logic [2:0]  w_x;
  logic [3:0]  w_y;
  logic        w_in_range;
  logic        w_hit;
  logic [6:0]  w_row_sum;
  logic [6:0]  w_prow;
  logic [11:0] w_addr;
  logic [8:0]  w_dly_in;
  logic [8:0]  w_tail;
  logic        w_valid;
  logic [7:0]  w_attr;

  assign w_col = hcount_in[10:3];
  assign w_row = vcount_in[9:4];
  assign w_x   = hcount_in[2:0];
  assign w_y   = vcount_in[3:0];

  // Gate on the state seen by this pixel; requests already queued are untouched.
  assign w_in_range = active_in && (w_col < c_cols8) && (w_row < c_rows6)
                      && (r_state == c_st_scan);

  // Both addends are below ROWS when in range, so one conditional subtract wraps.
  assign w_row_sum = {1'b0, w_row} + {2'b00, r_scroll_q};
  assign w_prow    = (w_row_sum >= c_rows7) ? (w_row_sum - c_rows7) : w_row_sum;
  assign w_addr    = ({5'd0, w_prow} * c_cols12) + {4'd0, w_col};

  always_ff @(posedge clk_hdmi_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= c_st_idle;
      r_scroll_q <= '0;
    end else if (frame_start_in) begin
      r_state    <= enable_in ? c_st_scan : c_st_idle;
      r_scroll_q <= (scroll_row_in >= c_rows5) ? 5'd0 : scroll_row_in;
    end
  end

  always_ff @(posedge clk_hdmi_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_text_addr <= '0;
    end else begin
      r_text_addr <= w_addr;
    end
  end

  assign text_addr_out = r_text_addr;

`ifdef TEXT_SCAN_CURSOR_EN
  localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);

  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_phase;

  always_ff @(posedge clk_hdmi_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_start_in) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
      end
    end
  end

  // Cursor is an underline on the bottom two texel rows of its screen cell.
  assign w_hit = r_blink_phase
                 && (w_col == {1'b0, cursor_col_in})
                 && (w_row == {1'b0, cursor_row_in})
                 && (w_y >= 4'd14);
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_col_in, cursor_row_in};
  assign w_hit           = 1'b0;
`endif

  assign w_dly_in = {w_in_range, w_hit, w_x, w_y};

  // Delay line spans the address register plus the text RAM read latency.
  always_ff @(posedge clk_hdmi_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < c_depth; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_dly[0] <= w_dly_in;
      for (int i = 1; i < c_depth; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign w_tail  = r_dly[c_depth-1];
  assign w_valid = w_tail[8];
  assign w_attr  = w_tail[7] ? {text_data_in[11:8], text_data_in[15:12]}
                             : text_data_in[15:8];

  assign font_valid_out      = w_valid;
  assign font_x_out          = w_valid ? w_tail[6:4]       : 3'd0;
  assign font_y_out          = w_valid ? w_tail[3:0]       : 4'd0;
  assign font_code_point_out = w_valid ? text_data_in[7:0] : 8'd0;
  assign font_attribute_out  = w_valid ? w_attr            : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_text_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_text_scan_ctrl
// Purpose  : Self-checking bench for text_scan_ctrl (cursor checks follow
//            TEXT_SCAN_CURSOR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_scan_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int LAT   = 2;
  localparam int BLINK = 2;
  localparam int HMAX  = 1024;
`ifdef TEXT_SCAN_CURSOR_EN
  localparam bit         CURSOR_EN  = 1'b1;
  localparam logic [7:0] c_hit_attr = 8'hF1;
`else
  localparam bit         CURSOR_EN  = 1'b0;
  localparam logic [7:0] c_hit_attr = 8'h1F;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, frame_start, active;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [4:0]  scroll_row, cursor_row;
  logic [6:0]  cursor_col;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic        font_valid;
  logic [2:0]  font_x;
  logic [3:0]  font_y;
  logic [7:0]  font_cp, font_attr;

  always #5 clk = ~clk;

  text_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .TEXT_RAM_LATENCY(LAT), .BLINK_FRAMES(BLINK)) dut (
    .clk_hdmi_in(clk), .rst_n_in(rst_n), .enable_in(enable), .frame_start_in(frame_start),
    .active_in(active), .hcount_in(hcount), .vcount_in(vcount), .scroll_row_in(scroll_row),
    .cursor_col_in(cursor_col), .cursor_row_in(cursor_row), .text_addr_out(text_addr),
    .text_data_in(text_data), .font_valid_out(font_valid), .font_x_out(font_x),
    .font_y_out(font_y), .font_code_point_out(font_cp), .font_attribute_out(font_attr)
  );

  // Text RAM with LAT cycles of read latency
  logic [15:0] mem [4096];
  logic [15:0] ram_pipe [LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= mem[text_addr];
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign text_data = ram_pipe[LAT-1];

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  // Expected outputs per cycle, circular on cycle index
  logic [11:0] e_addr [8];
  bit          e_addr_k [8];
  bit          e_v [8];
  logic [2:0]  e_x [8];
  logic [3:0]  e_y [8];
  logic [7:0]  e_cp [8], e_at [8];

  // Recorded DUT outputs per cycle for the literal checks
  logic [11:0] h_addr [HMAX];
  bit          h_v [HMAX];
  logic [2:0]  h_x [HMAX];
  logic [3:0]  h_y [HMAX];
  logic [7:0]  h_cp [HMAX], h_at [HMAX];

  // Model state: scan enable, latched scroll, frames since reset
  bit m_scan = 1'b0;
  int m_scroll = 0, m_frames = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 8; i++) begin
      e_addr[i] = '0; e_addr_k[i] = 1'b1; e_v[i] = 1'b0;
      e_x[i] = '0; e_y[i] = '0; e_cp[i] = '0; e_at[i] = '0;
    end
  endtask

  // Model: the pixel of cycle k gives the address at k+1 and font request at k+3
  always @(posedge clk) begin
    int k, col, row, a, s;
    bit inr, v, hit;
    logic [15:0] d;
    k = cyc;
    if (rst_n) begin
      col = int'(hcount[10:3]);
      row = int'(vcount[9:4]);
      inr = (col < COLS) && (row < ROWS);
      a   = ((row + m_scroll) % ROWS) * COLS + col;
      e_addr[(k+1)%8]   = 12'(a);
      e_addr_k[(k+1)%8] = inr;
      v   = m_scan && active && inr;
      d   = inr ? mem[12'(a)] : 16'h0;
      hit = CURSOR_EN && (col == int'(cursor_col)) && (row == int'(cursor_row))
            && (vcount[3:0] >= 4'd14) && (((m_frames / BLINK) % 2) == 1);
      s = (k + 3) % 8;
      e_v[s]  = v;
      e_x[s]  = v ? hcount[2:0] : 3'd0;
      e_y[s]  = v ? vcount[3:0] : 4'd0;
      e_cp[s] = v ? d[7:0] : 8'd0;
      e_at[s] = !v ? 8'd0 : (hit ? {d[11:8], d[15:12]} : d[15:8]);
      if (frame_start) begin
        m_scan   = enable;
        m_scroll = (int'(scroll_row) < ROWS) ? int'(scroll_row) : 0;
        m_frames++;
      end
    end else begin
      m_scan = 1'b0; m_scroll = 0; m_frames = 0;
    end
    cyc = k + 1;
  end

  // Single compare process, every cycle
  always @(negedge clk) begin
    int s;
    s = cyc % 8;
    if (!rst_n) clear_expect();
    if (cyc < HMAX) begin
      h_addr[cyc] = text_addr; h_v[cyc] = font_valid; h_x[cyc] = font_x;
      h_y[cyc] = font_y; h_cp[cyc] = font_cp; h_at[cyc] = font_attr;
    end
    if (e_addr_k[s]) chk("text_addr", int'(text_addr), int'(e_addr[s]));
    chk("font_valid", int'(font_valid), int'(e_v[s]));
    chk("font_x", int'(font_x), int'(e_x[s]));
    chk("font_y", int'(font_y), int'(e_y[s]));
    chk("font_code_point", int'(font_cp), int'(e_cp[s]));
    chk("font_attribute", int'(font_attr), int'(e_at[s]));
  end

  task automatic pix(input int h, input int v, input bit act, output int k);
    k = cyc;
    hcount = 11'(h); vcount = 10'(v); active = act; frame_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame(input bit en, input int scr, input int h, input int v,
                       input bit act, output int k);
    k = cyc;
    hcount = 11'(h); vcount = 10'(v); active = act;
    frame_start = 1'b1; enable = en; scroll_row = 5'(scr);
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    int k;
    for (int i = 0; i < n; i++) pix(0, 0, 1'b0, k);
  endtask

  initial begin
    int k, k1, ks0, ks1, ks2, ks3, ko0, ko1, ka, kb, kc, ke, ra, rb, rc, rd, rf;
    int kh [5];
    int kl [5];
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; active = 1'b0;
    hcount = '0; vcount = '0; scroll_row = '0; cursor_col = 7'd5; cursor_row = 5'd3;
    for (int i = 0; i < 4096; i++) mem[i] = 16'((i * 40503) ^ 16'h3c5a);
    mem[162] = 16'hA541;
    mem[245] = 16'h1F41;
    for (int i = 0; i < LAT; i++) ram_pipe[i] = '0;
    clear_expect();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: nothing issued
    pix(17, 35, 1'b1, k);
    idle(3);

    // Basic scan, scroll 0
    frame(1'b1, 0, 0, 0, 1'b0, k);
    pix(17, 35, 1'b1, k1);
    for (int h = 0; h < 24; h++) pix(h, 35 + (h % 3), 1'b1, k);
    idle(3);

    // Scroll wrap, mid-frame scroll change ignored, out-of-range scroll latched as 0
    frame(1'b1, 29, 0, 0, 1'b0, k);
    pix(24, 16, 1'b1, ks0);
    pix(24, 0, 1'b1, ks1);
    scroll_row = 5'd5;
    pix(24, 16, 1'b1, ks2);
    for (int v = 0; v < 64; v += 7) pix(100 + v, v, 1'b1, k);
    frame(1'b1, 31, 0, 0, 1'b0, k);
    pix(24, 16, 1'b1, ks3);
    idle(3);

    // Out of range: column 80, row 30, inactive
    frame(1'b1, 0, 0, 0, 1'b0, k);
    pix(640, 20, 1'b1, ko0);
    pix(17, 35, 1'b0, ko1);
    pix(17, 480, 1'b1, k);
    pix(639, 479, 1'b1, k);
    idle(3);

    // Cursor and blink, with a reset so the frame count is known
    rst_n = 1'b0;
    pix(0, 0, 1'b0, k);
    rst_n = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      frame(1'b1, 0, 0, 0, 1'b0, k);
      pix(40, 62, 1'b1, kh[f]);
      pix(40, 61, 1'b1, kl[f]);
      pix(41, 63, 1'b1, k);
      idle(2);
    end

    // Disable with in-flight requests, active pixel on the frame_start itself
    pix(17, 35, 1'b1, ka);
    frame(1'b0, 0, 17, 35, 1'b1, kb);
    pix(17, 35, 1'b1, kc);
    idle(4);
    frame(1'b1, 0, 0, 0, 1'b0, k);
    pix(17, 35, 1'b1, ke);
    idle(3);

    // One-cycle reset mid-line
    pix(16, 35, 1'b1, k);
    pix(17, 35, 1'b1, ra);
    pix(18, 35, 1'b1, rb);
    rst_n = 1'b0;
    pix(19, 35, 1'b1, rc);
    rst_n = 1'b1;
    pix(17, 35, 1'b1, rd);
    idle(3);
    frame(1'b1, 0, 0, 0, 1'b0, k);
    pix(17, 35, 1'b1, rf);
    idle(4);

    // Hand-computed expectations
    chk("lit addr 17,35", int'(h_addr[k1+1]), 162);
    chk("lit valid 17,35", int'(h_v[k1+3]), 1);
    chk("lit x 17,35", int'(h_x[k1+3]), 1);
    chk("lit y 17,35", int'(h_y[k1+3]), 3);
    chk("lit cp 17,35", int'(h_cp[k1+3]), 8'h41);
    chk("lit attr 17,35", int'(h_at[k1+3]), 8'hA5);
    chk("lit scroll wrap", int'(h_addr[ks0+1]), 3);
    chk("lit scroll row0", int'(h_addr[ks1+1]), 2323);
    chk("lit scroll midframe", int'(h_addr[ks2+1]), 3);
    chk("lit scroll clamp", int'(h_addr[ks3+1]), 83);
    chk("lit col80 valid", int'(h_v[ko0+3]), 0);
    chk("lit col80 cp", int'(h_cp[ko0+3]), 0);
    chk("lit inactive valid", int'(h_v[ko1+3]), 0);
    for (int f = 1; f <= 4; f++) begin
      chk("lit cursor attr", int'(h_at[kh[f]+3]), (f == 2 || f == 3) ? int'(c_hit_attr) : 8'h1F);
      chk("lit cursor y", int'(h_y[kh[f]+3]), 14);
      chk("lit y13 attr", int'(h_at[kl[f]+3]), 8'h1F);
    end
    chk("lit inflight before disable", int'(h_v[ka+3]), 1);
    chk("lit pixel on disable pulse", int'(h_v[kb+3]), 1);
    chk("lit after disable", int'(h_v[kc+3]), 0);
    chk("lit resume", int'(h_v[ke+3]), 1);
    chk("lit reset cycle valid", int'(h_v[rc]), 0);
    chk("lit reset cycle addr", int'(h_addr[rc]), 0);
    chk("lit flushed a", int'(h_v[ra+3]), 0);
    chk("lit flushed b", int'(h_v[rb+3]), 0);
    chk("lit idle after reset", int'(h_v[rd+3]), 0);
    chk("lit reenable", int'(h_v[rf+3]), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
